// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider (div_unit).
// Optional build macro DIV_FASTPATH_EN: see div_unit.sv.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 35;

  // Quotient returned when the divisor is zero
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem, q} left by one, trial-subtract
// the divisor and keep the difference when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Trial subtraction on WIDTH+1 bits so the borrow shows up in the MSB
  always_comb begin
    shifted_s = {rem, q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, divisor};
    if (!trial_s[WIDTH]) begin
      rem_next = trial_s[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// quotient -> LO, remainder -> HI; results held until the next operation.
// Build macro DIV_FASTPATH_EN: when defined, |dividend| < |divisor| skips the
// iteration phase (3-cycle latency, identical results).
import div_pkg::*;

module div_unit #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state_r;
  div_state_t       state_next_s;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sgn_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic [WIDTH-1:0] abs_dvd_s;
  logic [WIDTH-1:0] abs_dvs_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_q_s;
  logic             dvs_zero_s;
  logic             fast_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .divisor  (dvs_r),
    .rem_next (step_rem_s),
    .q_next   (step_q_s)
  );

  // Operand magnitudes from the captured raw operands (used during PREP)
  always_comb begin
    abs_dvd_s  = (sgn_r && dvd_r[WIDTH-1]) ? ({WIDTH{1'b0}} - dvd_r) : dvd_r;
    abs_dvs_s  = (sgn_r && dvs_r[WIDTH-1]) ? ({WIDTH{1'b0}} - dvs_r) : dvs_r;
    dvs_zero_s = (dvs_r == {WIDTH{1'b0}});
`ifdef DIV_FASTPATH_EN
    fast_s     = (abs_dvd_s < abs_dvs_s);
`else
    fast_s     = 1'b0;
`endif
  end

  // Next-state logic; cancel wins over every completion path
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && !cancel) state_next_s = PREP;
        else                  state_next_s = IDLE;
      end
      PREP: begin
        if (cancel)          state_next_s = IDLE;
        else if (dvs_zero_s) state_next_s = DONE;
        else if (fast_s)     state_next_s = FIX;
        else                 state_next_s = CALC;
      end
      CALC: begin
        if (cancel)                              state_next_s = IDLE;
        else if (cnt_r == CNT_W'(WIDTH - 1))     state_next_s = FIX;
        else                                     state_next_s = CALC;
      end
      FIX: begin
        if (cancel) state_next_s = IDLE;
        else        state_next_s = DONE;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus registered busy/done status decoded from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s != IDLE) && (state_next_s != DONE);
      done    <= (state_next_s == DONE);
    end
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sgn_r       <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !cancel) begin
            dvd_r       <= dividend;
            dvs_r       <= divisor;
            sgn_r       <= is_signed;
            div_by_zero <= 1'b0;
          end
        end
        PREP: begin
          if (!cancel) begin
            neg_q_r <= sgn_r & (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
            neg_r_r <= sgn_r & dvd_r[WIDTH-1];
            dvs_r   <= abs_dvs_s;
            cnt_r   <= {CNT_W{1'b0}};
            if (dvs_zero_s) begin
              // Zero divisor: all-ones quotient, dividend passed through raw
              quotient    <= DIV_ZERO_QUOT;
              remainder   <= dvd_r;
              div_by_zero <= 1'b1;
            end else if (fast_s) begin
              q_r   <= {WIDTH{1'b0}};
              rem_r <= abs_dvd_s;
            end else begin
              q_r   <= abs_dvd_s;
              rem_r <= {WIDTH{1'b0}};
            end
          end
        end
        CALC: begin
          rem_r <= step_rem_s;
          q_r   <= step_q_s;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        FIX: begin
          if (!cancel) begin
            quotient  <= neg_q_r ? ({WIDTH{1'b0}} - q_r)   : q_r;
            remainder <= neg_r_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
          end
        end
        default: begin
          // DONE: results already registered, nothing to update
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results built from
// a behavioural division model, checked when done pulses.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
    logic [31:0] z;
    z = 32'd0;
    return (s && v[31]) ? (z - v) : v;
  endfunction

  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    sa  = a;
    sbv = b;
    e.dbz = 1'b0;
    e.lat = div_pkg::DIV_LATENCY;
    if (b == 32'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 2;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (s) begin
      e.q = sa / sbv;
      e.r = sa % sbv;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
`ifdef DIV_FASTPATH_EN
    if (b != 32'd0 && mag(s, a) < mag(s, b)) e.lat = 3;
`endif
    return e;
  endfunction

  // Pulse start for one cycle at a negedge; optionally push the expected result
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
    if (push) sb.push_back(model(s, a, b));
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic wait_and_check(input string name);
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: done got %b expected 1 within 100 cycles", name, done);
      sb.delete();
    end else if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: done got 1 expected no result pending", name);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (cyc !== e.lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d expected %0d", name, cyc, e.lat);
      end
      n_checks++;
      if (quotient !== e.q) begin
        n_fail++;
        $display("FAIL %s_quotient: got %h expected %h", name, quotient, e.q);
      end
      n_checks++;
      if (remainder !== e.r) begin
        n_fail++;
        $display("FAIL %s_remainder: got %h expected %h", name, remainder, e.r);
      end
      n_checks++;
      if (div_by_zero !== e.dbz) begin
        n_fail++;
        $display("FAIL %s_dbz: got %b expected %b", name, div_by_zero, e.dbz);
      end
      n_checks++;
      if (busy_cnt !== e.lat - 1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_busy: got %0d busy cycles (busy at done %b) expected %0d (0)",
                 name, busy_cnt, busy, e.lat - 1);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: done got %b expected 0 one cycle later", name, done);
    end
  endtask

  // Watch for a stray done pulse over a window of cycles
  task automatic expect_no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d done pulses expected 0", name, seen);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    wait_and_check("divu_100_7");
  endtask

  task automatic test_signed();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_and_check("div_m7_2");
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_and_check("div_7_m2");
  endtask

  task automatic test_overflow();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_and_check("div_overflow");
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_and_check("divu_big");
  endtask

  task automatic test_div_zero();
    issue(1'b0, 32'd5, 32'd0, 1'b1);
    wait_and_check("divu_5_0");
    issue(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_and_check("div_m5_0");
  endtask

  task automatic test_cancel();
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    wait_and_check("cancel_setup");
    issue(1'b0, 32'd1000, 32'd3, 1'b0);
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    cancel   = 1'b1;
    start    = 1'b1;
    dividend = 32'd55;
    @(negedge clk);
    cancel = 1'b0;
    start  = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
      n_fail++;
      $display("FAIL cancel_calc: got busy=%b done=%b q=%h r=%h expected 0 0 0000000e 00000002",
               busy, done, quotient, remainder);
    end
    issue(1'b0, 32'd1000, 32'd3, 1'b1);
    wait_and_check("after_cancel");
    // cancel together with start in IDLE: start ignored
    cancel = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    start  = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_idle_start: busy got %b expected 0", busy);
    end
    expect_no_done("cancel_idle_no_done", 40);
    // cancel in FIX beats completion
    issue(1'b0, 32'd77, 32'd5, 1'b0);
    while (cyc < 34) begin
      @(negedge clk);
      cyc++;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 32'd333 || remainder !== 32'd1) begin
      n_fail++;
      $display("FAIL cancel_fix: got done=%b busy=%b q=%h r=%h expected 0 0 0000014d 00000001",
               done, busy, quotient, remainder);
    end
    expect_no_done("cancel_fix_no_done", 5);
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'd100, 32'd7, 1'b0);
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b dbz=%b q=%h r=%h expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    expect_no_done("reset_mid_no_done", 40);
  endtask

  task automatic test_start_busy();
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd10;
    wait_and_check("start_while_busy");
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done: busy got %b expected 0", busy);
    end
    start = 1'b0;
    expect_no_done("start_busy_no_done", 40);
  endtask

  task automatic test_fastpath();
    issue(1'b0, 32'd3, 32'd10, 1'b1);
    wait_and_check("divu_3_10");
    issue(1'b1, 32'hFFFF_FFFD, 32'd10, 1'b1);
    wait_and_check("div_m3_10");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case (i % 3)
        0:       b = 32'($urandom_range(1, 20));
        1:       b = $urandom;
        default: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
      endcase
      issue(s, a, b, 1'b1);
      wait_and_check("random");
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    cancel    = 1'b0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_div_zero();
    test_cancel();
    test_reset_mid();
    test_start_busy();
    test_fastpath();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
